int_ctrl: RTL
=============

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-003 irq_src  input  4  device interrupt lines, asynchronous to clk; rising edge = request.
REQ-004 Iack  input  1  CPU interrupt acknowledge; level, sampled on clk.
REQ-005 Ireq  output  1  interrupt request to CPU.
REQ-006 gntInt  output  4  one-hot granted source number; 0 when no grant.
REQ-007 stb_i  input  1  bus strobe for register access.
REQ-008 we_i  input  1  bus write enable, valid with stb_i.
REQ-009 addr_i  input  2  register select: 0 MASK, 1 PENDING, 2 STATUS, 3 EOI.
REQ-010 dat_i  input  32  bus write data.
REQ-011 dat_o  output  32  bus read data, valid while ack_o=1.
REQ-012 ack_o  output  1  bus acknowledge (drives CPU MIO_ready).

Function
REQ-013 Edge detect: pending[i] SHALL set on the clk following a 0->1 transition of sampled irq_src[i].
REQ-014 Registers: MASK[3:0] R/W (1 = enabled); PENDING[3:0] read, write-1-to-clear; STATUS = {27'b0, state[1:0], in_service[2:0]}, where in_service[2] = valid and in_service[1:0] = index; EOI write-only, reads 0; bits [31:4] of MASK/PENDING read 0.
REQ-015 Bus: ack_o SHALL pulse high for exactly one cycle, one cycle after a cycle with stb_i=1 and ack_o=0; writes take effect on the ack_o cycle; dat_o = 0 when ack_o=0.
REQ-016 Eligible set = PENDING & MASK; priority fixed, index 0 highest.
REQ-017 States: IDLE, REQ, SERVICE.
REQ-018 IDLE -> REQ when eligible set nonzero; on entry latch winner; Ireq=1 and gntInt=onehot(winner) from the next cycle.
REQ-019 REQ: grant is frozen; changes to MASK/PENDING or new higher-priority edges SHALL NOT alter gntInt or drop Ireq.
REQ-020 REQ -> SERVICE on Iack=1; in that cycle pending[winner] clears, Ireq and gntInt return to 0, in_service latches winner.
REQ-021 SERVICE: no new Ireq; new edges still set PENDING.
REQ-022 SERVICE -> IDLE on EOI write (any data); EOI in IDLE/REQ is ignored.
REQ-023 Simultaneous set and clear of the same pending bit (edge plus W1C or Iack clear): set wins.
REQ-024 Latency: edge on irq_src to Ireq=1 SHALL be exactly 2 cycles plus synchronizer depth (REQ-028), with MASK enabled, in IDLE, and no higher-priority request.

Reset
REQ-025 While reset=0: state=IDLE, MASK=0, PENDING=0, in_service=0, edge/sync flops=0, Ireq=0, gntInt=0, ack_o=0, dat_o=0.
REQ-026 Reset mid-handshake (REQ or SERVICE, or bus access pending) SHALL abort it; no ack_o or Ireq is produced after release until new stimulus.
REQ-027 After release, a level already high on irq_src SHALL register as an edge once sampled (previous-sample flop resets to 0).

Configuration
REQ-028 INT_CTRL_SYNC_EN defined: irq_src passes a 2-flop synchronizer before edge detection (depth 2). Undefined: irq_src feeds edge detection directly (depth 0), and sources must be clk-synchronous.

Verification
REQ-029 MASK=4'hF, pulse irq_src[2] in IDLE -> Ireq=1, gntInt=4'b0100 at cycle 2 (+2 with INT_CTRL_SYNC_EN); Iack=1 -> next cycle Ireq=0, gntInt=0, PENDING=0, STATUS in_service=3'b110.
REQ-030 MASK=4'hF, rising edges on irq_src[3] and [1] in the same cycle -> gntInt=4'b0010; after Iack and EOI -> second request with gntInt=4'b1000.
REQ-031 In REQ holding grant 4'b1000, edge on irq_src[0] -> gntInt stays 4'b1000 until Iack; PENDING reads 4'b1001 before Iack.
REQ-032 MASK=0, edge on irq_src[1] -> PENDING=4'b0010, Ireq stays 0; write MASK=4'h2 -> Ireq=1, gntInt=4'b0010; W1C write PENDING=4'h2 in IDLE before the request -> no Ireq.
REQ-033 Bus read of STATUS with stb_i held 3 cycles -> ack_o high on cycles 2 only, then again cycle 4; dat_o=0 outside ack cycles.
REQ-034 Drive reset=0 while in REQ with Ireq=1 -> Ireq, gntInt, MASK, PENDING all 0 immediately (asynchronous), state IDLE after release.

Source files
------------

// File: rtl/int_ctrl_bus_if.sv
// ============================================================================
// Module      : int_ctrl_bus_if
// Description : Register-access bus between a CPU-side master and int_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface int_ctrl_bus_if;
  logic        stb_i;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (
    output stb_i, we_i, addr_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  stb_i, we_i, addr_i, dat_i,
    output dat_o, ack_o
  );
endinterface

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
// Module      : int_ctrl
// Description : 4-source edge-triggered interrupt controller with fixed
//               priority (source 0 highest), REQ/SERVICE handshake and
//               register bus. Define INT_CTRL_SYNC_EN for a 2-flop input
//               synchronizer on irq_src.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic [3:0] irq_src,
  input  wire logic       Iack,
  output logic            Ireq,
  output logic [3:0]      gntInt,
  int_ctrl_bus_if.slave   bus
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_REQ     = 2'd1;
  localparam logic [1:0] c_ST_SERVICE = 2'd2;

  localparam logic [1:0] c_A_MASK    = 2'd0;
  localparam logic [1:0] c_A_PENDING = 2'd1;
  localparam logic [1:0] c_A_STATUS  = 2'd2;
  localparam logic [1:0] c_A_EOI     = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  r_mask;
  logic [3:0]  r_pending;
  logic [3:0]  r_irq_prev;
  logic [1:0]  r_winner;
  logic [2:0]  r_in_service;
  logic        r_ack;
  logic [31:0] r_dat;

  logic [3:0]  w_irq_s;
  logic [3:0]  w_edge;
  logic [3:0]  w_elig;
  logic        w_win_vld;
  logic [1:0]  w_win_idx;
  logic [3:0]  w_grant_oh;
  logic        w_access;
  logic        w_wr;
  logic        w_eoi_wr;
  logic        w_iack_take;
  logic [3:0]  w_pend_clr;
  logic [31:0] w_rdata;
  logic        w_unused;

`ifdef INT_CTRL_SYNC_EN
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 4'd0;
      r_sync2 <= 4'd0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_s = r_sync2;
`else
  assign w_irq_s = irq_src;
`endif

  // Previous-sample flop resets to 0 so a level held through reset counts as an edge.
  assign w_edge      = w_irq_s & ~r_irq_prev;
  assign w_elig      = r_pending & r_mask;
  assign w_win_vld   = |w_elig;
  assign w_grant_oh  = 4'b0001 << r_winner;

  assign w_access    = bus.stb_i & ~r_ack;
  assign w_wr        = w_access & bus.we_i;
  assign w_eoi_wr    = w_wr & (bus.addr_i == c_A_EOI);
  assign w_iack_take = (r_state == c_ST_REQ) & Iack;

  assign w_unused    = &{1'b0, bus.dat_i[31:4]};

  always_comb begin
    w_win_idx = 2'd0;
    casez (w_elig)
      4'b???1: w_win_idx = 2'd0;
      4'b??10: w_win_idx = 2'd1;
      4'b?100: w_win_idx = 2'd2;
      4'b1000: w_win_idx = 2'd3;
      default: w_win_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_pend_clr = 4'd0;
    if (w_wr && (bus.addr_i == c_A_PENDING))
      w_pend_clr = w_pend_clr | bus.dat_i[3:0];
    if (w_iack_take)
      w_pend_clr = w_pend_clr | w_grant_oh;
  end

  always_comb begin
    w_rdata = 32'd0;
    case (bus.addr_i)
      c_A_MASK:    w_rdata = {28'd0, r_mask};
      c_A_PENDING: w_rdata = {28'd0, r_pending};
      c_A_STATUS:  w_rdata = {27'd0, r_state, r_in_service};
      default:     w_rdata = 32'd0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (w_win_vld) w_state_nxt = c_ST_REQ;
      c_ST_REQ:     if (Iack)      w_state_nxt = c_ST_SERVICE;
      c_ST_SERVICE: if (w_eoi_wr)  w_state_nxt = c_ST_IDLE;
      default:                     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic: the grant is held purely by the latched winner while in REQ.
  always_comb begin
    Ireq   = 1'b0;
    gntInt = 4'd0;
    if (r_state == c_ST_REQ) begin
      Ireq   = 1'b1;
      gntInt = w_grant_oh;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_prev   <= 4'd0;
      r_pending    <= 4'd0;
      r_mask       <= 4'd0;
      r_winner     <= 2'd0;
      r_in_service <= 3'd0;
    end else begin
      r_irq_prev <= w_irq_s;
      // Edge set is OR'ed after the clear so a coincident set wins.
      r_pending  <= (r_pending & ~w_pend_clr) | w_edge;
      if (w_wr && (bus.addr_i == c_A_MASK))
        r_mask <= bus.dat_i[3:0];
      if ((r_state == c_ST_IDLE) && w_win_vld)
        r_winner <= w_win_idx;
      if (w_iack_take)
        r_in_service <= {1'b1, r_winner};
      else if ((r_state == c_ST_SERVICE) && w_eoi_wr)
        r_in_service <= 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_access;
      r_dat <= w_access ? w_rdata : 32'd0;
    end
  end

  assign bus.ack_o = r_ack;
  assign bus.dat_o = r_dat;

endmodule

`default_nettype wire
